// File: rtl/second_tick_gen_pkg.sv
// second_tick_gen_pkg: shared key FSM encoding, board clock rate and counter width helper
package second_tick_gen_pkg;
  localparam int unsigned CLK_HZ = 50_000_000;
  typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, REPEAT = 2'd2} key_state_t;
  function automatic int unsigned cw(input int unsigned n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/second_tick_gen_debounce.sv
// second_tick_gen_debounce: two-flop synchroniser plus stable-count debouncer for an active-low key
//   clock   in  board clock
//   reset_n in  asynchronous active-low reset
//   key_n   in  raw key, active low, asynchronous
//   pressed out debounced level, 1 = pressed
module second_tick_gen_debounce
  import second_tick_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic key_n,
  output logic pressed
);
  localparam int unsigned W = cw(DEBOUNCE_CYC);
  logic s1, s2;
  logic [W-1:0] cnt;
  // synchroniser resets to released so a key held through reset reads as a fresh press
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      cnt <= '0;
      pressed <= 1'b0;
    end else begin
      s1 <= key_n;
      s2 <= s1;
      if (~s2 == pressed) cnt <= '0;
      else if (cnt == W'(DEBOUNCE_CYC - 1)) begin
        pressed <= ~pressed;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/second_tick_gen.sv
// second_tick_gen: 1 Hz prescaler plus debounced ADVANCE key with auto-repeat, merged into one increment pulse
//   clock       in  board clock
//   reset_n     in  asynchronous active-low reset
//   key_adv_n   in  raw ADVANCE key, active low
//   run_en      in  enables natural ticks; low clears the prescaler
//   tick_1hz    out one-cycle pulse every DIV_COUNT cycles
//   increment   out one-cycle pulse to the seconds counter
//   adjusting   out key FSM not idle
//   key_pressed out debounced key level
module second_tick_gen
  import second_tick_gen_pkg::*;
#(
  parameter int unsigned DIV_COUNT         = CLK_HZ,
  parameter int unsigned DEBOUNCE_CYC      = 1_000_000,
  parameter int unsigned REPEAT_DELAY_CYC  = 25_000_000,
  parameter int unsigned REPEAT_PERIOD_CYC = 5_000_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic key_adv_n,
  input  logic run_en,
  output logic tick_1hz,
  output logic increment,
  output logic adjusting,
  output logic key_pressed
);
  localparam int unsigned DW = cw(DIV_COUNT);
  localparam int unsigned HW = cw(REPEAT_DELAY_CYC > REPEAT_PERIOD_CYC ? REPEAT_DELAY_CYC : REPEAT_PERIOD_CYC);
  logic [DW-1:0] pcnt;
  logic [HW-1:0] hcnt, hcnt_n;
  key_state_t state, state_n;
  logic prev, manual, natural;
  second_tick_gen_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb (
    .clock(clock),
    .reset_n(reset_n),
    .key_n(key_adv_n),
    .pressed(key_pressed)
  );
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      pcnt <= '0;
      tick_1hz <= 1'b0;
    end else if (!run_en) begin
      pcnt <= '0;
      tick_1hz <= 1'b0;
    end else begin
      tick_1hz <= pcnt == DW'(DIV_COUNT - 1);
      pcnt <= pcnt == DW'(DIV_COUNT - 1) ? '0 : pcnt + 1'b1;
    end
  // the ~increment term keeps back-to-back sources from producing a two-cycle pulse
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      hcnt <= '0;
      prev <= 1'b0;
      increment <= 1'b0;
    end else begin
      state <= state_n;
      hcnt <= hcnt_n;
      prev <= key_pressed;
      increment <= (manual | natural) & ~increment;
    end
  always_comb begin
    state_n = state;
    hcnt_n = hcnt + 1'b1;
    manual = 1'b0;
    case (state)
      IDLE: begin
        hcnt_n = '0;
        if (key_pressed & ~prev) begin
          manual = 1'b1;
          state_n = DELAY;
        end
      end
      DELAY:
        if (!key_pressed) state_n = IDLE;
        else if (hcnt == HW'(REPEAT_DELAY_CYC - 1)) begin
          manual = 1'b1;
          hcnt_n = '0;
          state_n = REPEAT;
        end
      REPEAT: begin
        if (hcnt == HW'(REPEAT_PERIOD_CYC - 1)) begin
          manual = 1'b1;
          hcnt_n = '0;
        end
        if (!key_pressed) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  assign natural = tick_1hz & run_en & (state == IDLE);
  assign adjusting = state != IDLE;
endmodule
